// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read-port and output-stream signals between the read controller and its neighbours.
// master = controller side (drives the read strobe and the stream), slave = FIFO/consumer side.
interface fifo_rd_ctrl_if #(
    parameter int W = 4
);
    logic         fifo_empty;
    logic [W-1:0] fifo_data;
    logic         fifo_rd_n;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_n, m_data, m_valid
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_n, m_data, m_valid
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Pops a fixed-latency FIFO into a RD_LAT+1 entry buffer and serves it as a valid/ready stream.
// Word reaches m_valid RD_LAT+1 edges after the read strobe; m_ready low stalls reads via credits.
module fifo_rd_ctrl #(
    parameter int W      = 4,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    fifo_rd_ctrl_if.master   bus,
    output logic [CNT_W-1:0] pop_cnt
);
    localparam int BUF = RD_LAT + 1;
    localparam int PW  = (BUF > 2) ? 2 : 1;
    localparam int OW  = PW + 1;

    logic [W-1:0]      buf_q [BUF];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [OW-1:0]     occ_q;
    logic [RD_LAT-1:0] inf_q;
    logic              pop;
    logic              cap;
    logic              rd;
    logic [3:0]        used;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop  = bus.m_valid & bus.m_ready;
    assign cap  = inf_q[RD_LAT-1];

    // Buffered plus in-flight words, counting the slot freed by this cycle's pop.
    assign used = 4'(occ_q) + 4'($countones(inf_q)) - {3'b000, pop};
    assign rd   = reset_n & enable & ~bus.fifo_empty & (used < 4'(BUF));

    assign bus.fifo_rd_n = ~rd;
    assign bus.m_valid   = (occ_q != '0);
    assign bus.m_data    = buf_q[head_q];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF; i++) begin
                buf_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            inf_q   <= '0;
            pop_cnt <= '0;
        end else begin
            inf_q <= (inf_q << 1) | RD_LAT'(rd);
            if (cap) begin
                buf_q[tail_q] <= bus.fifo_data;
                tail_q        <= nxt(tail_q);
            end
            if (pop) begin
                head_q  <= nxt(head_q);
                pop_cnt <= pop_cnt + CNT_W'(1);
            end
            occ_q <= occ_q + OW'(cap) - OW'(pop);
        end
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: queue-based FIFO with one-cycle read latency, scoreboard of accepted words.
module tb_fifo_rd_ctrl;
    localparam int W      = 4;
    localparam int RD_LAT = 1;
    localparam int CNT_W  = 4;
    localparam int BUF    = RD_LAT + 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [CNT_W-1:0] pop_cnt;

    fifo_rd_ctrl_if #(.W(W)) bus ();

    fifo_rd_ctrl #(.W(W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus.master),
        .pop_cnt (pop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [W-1:0] fifo_q [$];
    logic [W-1:0] got_q  [$];
    int           rd_cyc [$];
    int           pop_cyc[$];
    int cyc = 0, rd_cnt = 0, rd_tot = 0, acc_tot = 0, max_out = 0, bad_rd = 0, hold_viol = 0;

    logic             s_rd_n = 1'b1, s_valid = 1'b0, s_ready = 1'b0, s_rst = 1'b0;
    logic [W-1:0]     s_data = '0;
    logic [CNT_W-1:0] s_cnt  = '0;
    logic             p_valid, p_ready, p_rst;
    logic [W-1:0]     p_data;

    // One clock: sample everything at the falling edge, then model the FIFO and consumer after the rise.
    task automatic tick();
        @(negedge clk);
        p_valid = s_valid; p_ready = s_ready; p_data = s_data; p_rst = s_rst;
        s_rd_n  = bus.fifo_rd_n; s_valid = bus.m_valid; s_ready = bus.m_ready;
        s_data  = bus.m_data;    s_cnt   = pop_cnt;     s_rst   = reset_n;
        if (p_rst && p_valid && !p_ready && (!s_valid || s_data !== p_data)) hold_viol++;
        if (!s_rd_n && fifo_q.size() == 0) bad_rd++;
        if (!s_rd_n) begin rd_cnt++; rd_cyc.push_back(cyc); end
        @(posedge clk); #1;
        if (!s_rst) begin
            acc_tot = 0; rd_tot = 0;
        end else begin
            if (s_valid && s_ready) begin got_q.push_back(s_data); pop_cyc.push_back(cyc); acc_tot++; end
            if (!s_rd_n) rd_tot++;
            if (rd_tot - acc_tot > max_out) max_out = rd_tot - acc_tot;
        end
        if (!s_rd_n && fifo_q.size() != 0) bus.fifo_data = fifo_q.pop_front();
        else                               bus.fifo_data = W'($urandom);
        bus.fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic clear_log();
        got_q.delete(); rd_cyc.delete(); pop_cyc.delete();
        rd_cnt = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; bus.m_ready = 1'b1;
        push(4'h5); push(4'h6);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (s_rd_n !== 1'b1) $display("FAIL reset_rd_n: got %b want 1", s_rd_n); else passed++;
            checks++; if (s_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", s_valid); else passed++;
            checks++; if (s_data !== '0) $display("FAIL reset_data: got %h want 0", s_data); else passed++;
            checks++; if (s_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", s_cnt); else passed++;
        end
        fifo_q.delete(); bus.fifo_empty = 1'b1;
        reset_n = 1'b1;
        tick();
        clear_log();
    endtask

    task automatic test_stream();
        clear_log();
        bus.m_ready = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 8; i++) push(W'(i));
        for (int t = 0; t < 40 && got_q.size() < 8; t++) tick();
        for (int t = 0; t < 3; t++) tick();
        checks++; if (rd_cnt != 8) $display("FAIL stream_reads: got %0d want 8", rd_cnt); else passed++;
        checks++; if (rd_cnt == 8 && rd_cyc[7] - rd_cyc[0] != 7)
            $display("FAIL stream_rd_contig: span %0d want 7", rd_cyc[7] - rd_cyc[0]); else passed++;
        checks++; if (got_q.size() != 8) $display("FAIL stream_count: got %0d want 8", got_q.size()); else passed++;
        for (int i = 0; i < got_q.size() && i < 8 && rd_cyc.size() > 0; i++) begin
            checks++; if (got_q[i] !== W'(i + 1)) $display("FAIL stream_word%0d: got %h want %h", i, got_q[i], W'(i + 1)); else passed++;
            checks++; if (pop_cyc[i] != rd_cyc[0] + RD_LAT + 1 + i)
                $display("FAIL stream_time%0d: cycle %0d want %0d", i, pop_cyc[i], rd_cyc[0] + RD_LAT + 1 + i); else passed++;
        end
        checks++; if (s_cnt !== CNT_W'(8)) $display("FAIL stream_pop_cnt: got %0d want 8", s_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        clear_log();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(W'(i));
        for (int t = 0; t < 8; t++) tick();
        checks++; if (rd_cnt != BUF) $display("FAIL bp_reads: got %0d want %0d", rd_cnt, BUF); else passed++;
        checks++; if (s_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", s_valid); else passed++;
        checks++; if (s_data !== 4'h1) $display("FAIL bp_head: got %h want 1", s_data); else passed++;
        bus.m_ready = 1'b1;
        for (int t = 0; t < 40 && got_q.size() < 6; t++) tick();
        for (int t = 0; t < 2; t++) tick();
        checks++; if (got_q.size() != 6) $display("FAIL bp_count: got %0d want 6", got_q.size()); else passed++;
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            checks++; if (got_q[i] !== W'(i + 1)) $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], W'(i + 1)); else passed++;
        end
    endtask

    task automatic test_empty_boundary();
        clear_log();
        bus.m_ready = 1'b1;
        push(4'hA);
        for (int t = 0; t < 6; t++) tick();
        checks++; if (rd_cnt != 1) $display("FAIL empty_reads: got %0d want 1", rd_cnt); else passed++;
        checks++; if (s_rd_n !== 1'b1) $display("FAIL empty_rd_n: got %b want 1", s_rd_n); else passed++;
        push(4'hB);
        tick();
        checks++; if (s_rd_n !== 1'b0) $display("FAIL empty_refetch: got %b want 0", s_rd_n); else passed++;
        for (int t = 0; t < 4; t++) tick();
        checks++; if (got_q.size() != 2) $display("FAIL empty_count: got %0d want 2", got_q.size()); else passed++;
        if (got_q.size() == 2) begin
            checks++; if (got_q[0] !== 4'hA || got_q[1] !== 4'hB)
                $display("FAIL empty_words: got %h %h want a b", got_q[0], got_q[1]); else passed++;
        end
    endtask

    task automatic test_enable_drop();
        clear_log();
        bus.m_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 8; i++) push(W'(i + 3));
        for (int t = 0; t < 3; t++) tick();
        enable = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        checks++; if (rd_cnt != 3) $display("FAIL en_reads_off: got %0d want 3", rd_cnt); else passed++;
        checks++; if (got_q.size() != 3) $display("FAIL en_inflight: got %0d want 3", got_q.size()); else passed++;
        enable = 1'b1;
        for (int t = 0; t < 40 && got_q.size() < 8; t++) tick();
        for (int t = 0; t < 2; t++) tick();
        checks++; if (rd_cnt != 8) $display("FAIL en_reads: got %0d want 8", rd_cnt); else passed++;
        checks++; if (got_q.size() != 8) $display("FAIL en_count: got %0d want 8", got_q.size()); else passed++;
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            checks++; if (got_q[i] !== W'(i + 3)) $display("FAIL en_word%0d: got %h want %h", i, got_q[i], W'(i + 3)); else passed++;
        end
    endtask

    task automatic test_wrap_reset();
        logic [W-1:0] exp_q [$];
        reset_n = 1'b0; tick();
        reset_n = 1'b1; tick();
        checks++; if (s_cnt !== '0) $display("FAIL wrap_start: got %0d want 0", s_cnt); else passed++;
        clear_log();
        enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            push(w); exp_q.push_back(w);
        end
        for (int t = 0; t < 300 && got_q.size() < 17; t++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        checks++; if (got_q.size() != 17) $display("FAIL wrap_count: got %0d want 17", got_q.size()); else passed++;
        for (int i = 0; i < got_q.size() && i < 17; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL wrap_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else passed++;
        end
        checks++; if (s_cnt !== CNT_W'(1)) $display("FAIL wrap_pop_cnt: got %0d want 1", s_cnt); else passed++;
        bus.m_ready = 1'b0;
        push(4'h7); push(4'h8);
        for (int t = 0; t < 5; t++) tick();
        checks++; if (s_valid !== 1'b1) $display("FAIL wrap_full_valid: got %b want 1", s_valid); else passed++;
        reset_n = 1'b0; tick();
        checks++; if (s_rd_n !== 1'b1) $display("FAIL midrst_rd_n: got %b want 1", s_rd_n); else passed++;
        fifo_q.delete(); bus.fifo_empty = 1'b1;
        reset_n = 1'b1; tick();
        checks++; if (s_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", s_valid); else passed++;
        checks++; if (s_cnt !== '0) $display("FAIL midrst_cnt: got %0d want 0", s_cnt); else passed++;
        checks++; if (s_data !== '0) $display("FAIL midrst_data: got %h want 0", s_data); else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q [$];
        int           bad;
        clear_log();
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) begin
                logic [W-1:0] w;
                w = W'($urandom);
                push(w); exp_q.push_back(w);
            end
            bus.m_ready = ($urandom_range(0, 3) != 0);
            enable      = ($urandom_range(0, 5) != 0);
            tick();
        end
        enable = 1'b1; bus.m_ready = 1'b1;
        for (int t = 0; t < 100 && got_q.size() < exp_q.size(); t++) tick();
        tick();
        checks++; if (got_q.size() != exp_q.size())
            $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) $display("FAIL rand_order: %0d words differ, want 0", bad); else passed++;
        checks++; if (s_cnt !== CNT_W'(acc_tot)) $display("FAIL rand_pop_cnt: got %0d want %0d", s_cnt, CNT_W'(acc_tot)); else passed++;
        checks++; if (bad_rd != 0) $display("FAIL empty_read: got %0d reads of empty FIFO want 0", bad_rd); else passed++;
        checks++; if (hold_viol != 0) $display("FAIL hold_stable: got %0d violations want 0", hold_viol); else passed++;
        checks++; if (max_out > BUF) $display("FAIL credit_bound: outstanding %0d want <= %0d", max_out, BUF); else passed++;
    endtask

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b0;
        bus.m_ready    = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_boundary();
        test_enable_drop();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
